// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline-boundary register between two processor stages. It carries an
// opaque payload with a valid/ready handshake, supports a synchronous flush
// that inserts a bubble, and can optionally use a 2-entry skid buffer so that
// o_ready comes straight from a flop. A saturating counter records the cycles
// the stage held valid data that downstream refused.
//
// Parameters:
//   DATA_W     payload width in bits
//   BUBBLE_VAL payload driven when the stage is empty, flushed or in reset
//   SKID       1 = main + skid entry, registered o_ready
//              0 = single entry, combinational o_ready
//   CNT_W      stall counter width
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_reset      asynchronous active-low reset
//   i_flush      synchronous flush, drops held entries and the current input
//   i_valid      upstream payload valid
//   o_ready      stage can accept a payload this cycle
//   i_data       upstream payload
//   o_valid      payload on o_data is valid
//   i_ready      downstream accepts o_data this cycle
//   o_data       registered payload to the next stage
//   o_stall_cnt  saturating count of cycles with o_valid=1 and i_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int                DATA_W     = 128,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
   parameter bit                SKID       = 1'b1,
   parameter int                CNT_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                ready_q;
   logic                ready_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                in_fire;
   logic                out_fire;

   // The main entry is always the one presented downstream; skid only ever
   // holds the younger of two entries, which keeps the ordering FIFO.
   assign o_valid     = (state_q != EMPTY);
   assign o_data      = main_q;
   assign o_stall_cnt = cnt_q;

   // With the skid buffer, ready is a flop so no combinational path runs
   // back from downstream ready to upstream. Without it, the single entry
   // can accept whenever it is empty or draining this cycle.
   assign o_ready  = SKID ? ready_q : (!o_valid | i_ready);
   assign in_fire  = i_valid & o_ready;
   assign out_fire = o_valid & i_ready;

   // Next-state and datapath selection. Flush wins over every handshake; an
   // out_fire in the flush cycle is still delivered because downstream has
   // already taken it, while the in_fire payload is simply never stored.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (i_flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = i_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = i_data;
               end else if (in_fire) begin
                  // Only reachable with the skid buffer: without it, ready in
                  // ONE equals i_ready, so in_fire implies out_fire.
                  if (SKID) begin
                     skid_d  = i_data;
                     state_d = TWO;
                  end else begin
                     main_d = i_data;
                  end
               end else if (out_fire) begin
                  main_d  = BUBBLE_VAL;
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end

      ready_d = (state_d != TWO);
   end

   // Stage state registers; every flop has a defined reset value so nothing
   // undefined ever reaches the next stage.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

   // Stall counter for performance debug. It saturates instead of wrapping
   // and is deliberately left untouched by flush.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else if (o_valid && !i_ready && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. Three instances share one clock
// and one reset: a 128-bit skid-buffered stage fed through a scoreboard, a
// single-register stage (SKID=0) and a stage with a 4-bit stall counter for
// saturation checks.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int          DW          = 128;
   localparam logic [DW-1:0] MAIN_BUBBLE = 128'h0000_0013;
   localparam logic [31:0] NARROW_BUBBLE = 32'h0000_0013;

   logic clk;
   logic reset_n;

   // Main skid-buffered instance
   logic          m_flush, m_valid, m_ready_out, m_valid_out, m_ready;
   logic [DW-1:0] m_data, m_data_out;
   logic [15:0]   m_cnt;

   // Single-register instance
   logic        s0_flush, s0_valid, s0_ready_out, s0_valid_out, s0_ready;
   logic [31:0] s0_data, s0_data_out;
   logic [15:0] s0_cnt;

   // Narrow-counter instance
   logic        st_flush, st_valid, st_ready_out, st_valid_out, st_ready;
   logic [31:0] st_data, st_data_out;
   logic [3:0]  st_cnt;

   int vectors;
   int miscompares;
   logic [DW-1:0] sb[$];

   pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(MAIN_BUBBLE), .SKID(1'b1), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset(reset_n), .i_flush(m_flush), .i_valid(m_valid),
      .o_ready(m_ready_out), .i_data(m_data), .o_valid(m_valid_out),
      .i_ready(m_ready), .o_data(m_data_out), .o_stall_cnt(m_cnt)
   );

   pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(NARROW_BUBBLE), .SKID(1'b0), .CNT_W(16)) dut_s0 (
      .i_clk(clk), .i_reset(reset_n), .i_flush(s0_flush), .i_valid(s0_valid),
      .o_ready(s0_ready_out), .i_data(s0_data), .o_valid(s0_valid_out),
      .i_ready(s0_ready), .o_data(s0_data_out), .o_stall_cnt(s0_cnt)
   );

   pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(NARROW_BUBBLE), .SKID(1'b1), .CNT_W(4)) dut_sat (
      .i_clk(clk), .i_reset(reset_n), .i_flush(st_flush), .i_valid(st_valid),
      .o_ready(st_ready_out), .i_data(st_data), .o_valid(st_valid_out),
      .i_ready(st_ready), .o_data(st_data_out), .o_stall_cnt(st_cnt)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle on the main instance. At the falling edge it records
   // whether an item leaves (popping the oldest expected payload) and pushes
   // the accepted input; flush empties the expected queue after the pop.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                                input logic f, output logic fired, output logic have_exp,
                                output logic [DW-1:0] got, output logic [DW-1:0] exp);
      m_valid = v;
      m_data  = d;
      m_ready = r;
      m_flush = f;
      @(negedge clk);
      fired    = m_valid_out & m_ready;
      got      = m_data_out;
      have_exp = 1'b0;
      exp      = '0;
      if (fired && sb.size() > 0) begin
         exp      = sb.pop_front();
         have_exp = 1'b1;
      end
      if (f) sb.delete();
      else if (v && m_ready_out) sb.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic fired, have_exp;
      logic [DW-1:0] got, exp;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (m_valid_out !== 1'b0 || m_data_out !== MAIN_BUBBLE || m_cnt !== 16'd0 || m_ready_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_idle: valid=%b data=%h cnt=%0d ready=%b, want 0/%h/0/1",
                  m_valid_out, m_data_out, m_cnt, m_ready_out, MAIN_BUBBLE);
      end
      vectors++;
      if (s0_valid_out !== 1'b0 || s0_data_out !== NARROW_BUBBLE || st_cnt !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_others: s0_valid=%b s0_data=%h st_cnt=%0d, want 0/%h/0",
                  s0_valid_out, s0_data_out, st_cnt, NARROW_BUBBLE);
      end
      // Load a payload, let it stall one cycle, then reset between edges
      applyStimulus(1'b1, 128'hDEAD_BEEF, 1'b0, 1'b0, fired, have_exp, got, exp);
      vectors++;
      if (m_valid_out !== 1'b1 || m_data_out !== 128'hDEAD_BEEF) begin
         miscompares++;
         $display("[TB] FAIL reset_preload: valid=%b data=%h, want 1/deadbeef", m_valid_out, m_data_out);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, fired, have_exp, got, exp);
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (m_valid_out !== 1'b0 || m_data_out !== MAIN_BUBBLE || m_cnt !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_async: valid=%b data=%h cnt=%0d, want 0/%h/0",
                  m_valid_out, m_data_out, m_cnt, MAIN_BUBBLE);
      end
      sb.delete();
      m_valid = 1'b1;
      m_data  = 128'hBAD;
      @(posedge clk);
      #1;
      vectors++;
      if (m_valid_out !== 1'b0 || m_ready_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_no_capture: valid=%b ready=%b, want 0/1", m_valid_out, m_ready_out);
      end
      m_valid = 1'b0;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (m_ready_out !== 1'b1 || m_valid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release: ready=%b valid=%b, want 1/0", m_ready_out, m_valid_out);
      end
   endtask

   task automatic test_streaming();
      logic fired, have_exp;
      logic [DW-1:0] got, exp;
      int delivered;
      delivered = 0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(k < 4, DW'(k + 1), 1'b1, 1'b0, fired, have_exp, got, exp);
         if (fired) begin
            delivered++;
            vectors++;
            if (!have_exp || got !== exp) begin
               miscompares++;
               $display("[TB] FAIL stream_data: got %h expected %h (queued=%b)", got, exp, have_exp);
            end
         end
         if (k < 4) begin
            vectors++;
            if (m_data_out !== DW'(k + 1) || m_ready_out !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL stream_latency: data=%h ready=%b, want %0d/1", m_data_out, m_ready_out, k + 1);
            end
         end
      end
      vectors++;
      if (delivered != 4 || m_cnt !== 16'd0 || m_valid_out !== 1'b0 || m_data_out !== MAIN_BUBBLE) begin
         miscompares++;
         $display("[TB] FAIL stream_end: delivered=%0d cnt=%0d valid=%b data=%h, want 4/0/0/bubble",
                  delivered, m_cnt, m_valid_out, m_data_out);
      end
   endtask

   task automatic test_backpressure();
      logic fired, have_exp;
      logic [DW-1:0] got, exp;
      int delivered;
      delivered = 0;
      // Rows: A, B, five held cycles offering 0x99 (must be refused), then drain
      for (int i = 0; i < 9; i++) begin
         if (i == 0)      applyStimulus(1'b1, 128'h11, 1'b0, 1'b0, fired, have_exp, got, exp);
         else if (i == 1) applyStimulus(1'b1, 128'h22, 1'b0, 1'b0, fired, have_exp, got, exp);
         else if (i < 7)  applyStimulus(1'b1, 128'h99, 1'b0, 1'b0, fired, have_exp, got, exp);
         else             applyStimulus(1'b0, '0, 1'b1, 1'b0, fired, have_exp, got, exp);
         if (fired) begin
            delivered++;
            vectors++;
            if (!have_exp || got !== exp) begin
               miscompares++;
               $display("[TB] FAIL bp_order: got %h expected %h (queued=%b)", got, exp, have_exp);
            end
         end
         if (i == 1) begin
            vectors++;
            if (m_ready_out !== 1'b0 || m_data_out !== 128'h11 || m_valid_out !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL bp_two: ready=%b data=%h valid=%b, want 0/11/1", m_ready_out, m_data_out, m_valid_out);
            end
         end
         if (i == 6) begin
            vectors++;
            if (m_cnt !== 16'd6) begin
               miscompares++;
               $display("[TB] FAIL bp_stall_cnt: got %0d, want 6", m_cnt);
            end
         end
         if (i == 7) begin
            vectors++;
            if (m_ready_out !== 1'b1 || m_data_out !== 128'h22) begin
               miscompares++;
               $display("[TB] FAIL bp_reopen: ready=%b data=%h, want 1/22", m_ready_out, m_data_out);
            end
         end
      end
      vectors++;
      if (delivered != 2 || sb.size() != 0 || m_cnt !== 16'd6 || m_valid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_end: delivered=%0d left=%0d cnt=%0d valid=%b, want 2/0/6/0",
                  delivered, sb.size(), m_cnt, m_valid_out);
      end
   endtask

   task automatic test_flush();
      logic fired, have_exp;
      logic [DW-1:0] got, exp;
      // Fill both entries, then flush while 0x33 is offered
      for (int i = 0; i < 7; i++) begin
         if (i == 0)      applyStimulus(1'b1, 128'h44, 1'b0, 1'b0, fired, have_exp, got, exp);
         else if (i == 1) applyStimulus(1'b1, 128'h55, 1'b0, 1'b0, fired, have_exp, got, exp);
         else if (i == 2) applyStimulus(1'b1, 128'h33, 1'b0, 1'b1, fired, have_exp, got, exp);
         else if (i == 3) applyStimulus(1'b0, '0, 1'b1, 1'b0, fired, have_exp, got, exp);
         else if (i == 4) applyStimulus(1'b1, 128'h66, 1'b1, 1'b0, fired, have_exp, got, exp);
         else if (i == 5) applyStimulus(1'b1, 128'h77, 1'b1, 1'b1, fired, have_exp, got, exp);
         else             applyStimulus(1'b0, '0, 1'b1, 1'b0, fired, have_exp, got, exp);
         if (fired) begin
            vectors++;
            if (!have_exp || got !== exp) begin
               miscompares++;
               $display("[TB] FAIL flush_data: got %h expected %h (queued=%b)", got, exp, have_exp);
            end
         end
         if (i == 2 || i == 3 || i == 5 || i == 6) begin
            vectors++;
            if (m_valid_out !== 1'b0 || m_data_out !== MAIN_BUBBLE || m_ready_out !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL flush_bubble step %0d: valid=%b data=%h ready=%b, want 0/%h/1",
                        i, m_valid_out, m_data_out, m_ready_out, MAIN_BUBBLE);
            end
         end
      end
      vectors++;
      if (m_cnt !== 16'd8 || sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL flush_cnt: cnt=%0d left=%0d, want 8/0", m_cnt, sb.size());
      end
   endtask

   task automatic test_no_skid();
      vectors++;
      if (s0_ready_out !== 1'b1 || s0_valid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL s0_idle: ready=%b valid=%b, want 1/0", s0_ready_out, s0_valid_out);
      end
      s0_valid = 1'b1;
      s0_data  = 32'hA1;
      s0_ready = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (s0_valid_out !== 1'b1 || s0_data_out !== 32'hA1 || s0_ready_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL s0_hold: valid=%b data=%h ready=%b, want 1/a1/0", s0_valid_out, s0_data_out, s0_ready_out);
      end
      s0_data  = 32'hA2;
      s0_ready = 1'b1;
      #1;
      vectors++;
      if (s0_ready_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL s0_comb_ready: got %b, want 1", s0_ready_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (s0_valid_out !== 1'b1 || s0_data_out !== 32'hA2) begin
         miscompares++;
         $display("[TB] FAIL s0_back_to_back: valid=%b data=%h, want 1/a2", s0_valid_out, s0_data_out);
      end
      s0_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (s0_valid_out !== 1'b0 || s0_data_out !== NARROW_BUBBLE || s0_ready_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL s0_drain: valid=%b data=%h ready=%b, want 0/13/1", s0_valid_out, s0_data_out, s0_ready_out);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] want;
      st_valid = 1'b1;
      st_data  = 32'h5;
      st_ready = 1'b0;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         want = (i < 15) ? 4'(i) : 4'd15;
         if (i == 14 || i == 15 || i == 20) begin
            vectors++;
            if (st_cnt !== want) begin
               miscompares++;
               $display("[TB] FAIL sat_cnt cycle %0d: got %0d, want %0d", i, st_cnt, want);
            end
         end
      end
      st_flush = 1'b1;
      @(posedge clk);
      #1;
      st_flush = 1'b0;
      vectors++;
      if (st_valid_out !== 1'b0 || st_cnt !== 4'd15) begin
         miscompares++;
         $display("[TB] FAIL sat_flush: valid=%b cnt=%0d, want 0/15", st_valid_out, st_cnt);
      end
   endtask

   // Test sequence
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n  = 1'b0;
      m_flush  = 1'b0; m_valid  = 1'b0; m_ready  = 1'b1; m_data  = '0;
      s0_flush = 1'b0; s0_valid = 1'b0; s0_ready = 1'b1; s0_data = '0;
      st_flush = 1'b0; st_valid = 1'b0; st_ready = 1'b1; st_data = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_no_skid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
